// File: rtl/ds_decim_pkg.sv
// Purpose: shared types and helpers for the delta-sigma bitstream CIC decimator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   MAX_ORDER    - largest supported number of integrator/comb stages
//   comb_state_t - serial comb FSM state (idle, or running one comb stage per clock)
//   decim_width  - datapath width needed so the final comb output is exact

package ds_decim_pkg;

    localparam int MAX_ORDER = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_COMB = 1'b1
    } comb_state_t;

    // The CIC gain is R^ORDER = 2^(ORDER*DECIM_LOG2), which must itself be
    // representable, hence the extra bit.
    function automatic int decim_width(input int order, input int decim_log2);
        return order * decim_log2 + 1;
    endfunction

endpackage

// File: rtl/ds_cic_comb_serial.sv
// Purpose: serial CIC comb section, one differentiator stage evaluated per clock.
// Latency: ORDER clocks from start to the done pulse; result is valid while done is high and after.
// Backpressure: none; start must only arrive while idle (the caller's decimation spacing ensures this).
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   start       - load snapshot into x and begin stage 0 on the next clock
//   snapshot    - last integrator value captured at the decimation point
//   busy        - a comb stage is pending or executing
//   done        - one-cycle pulse the clock after the last stage completed
//   result      - comb output (the x register)

module ds_cic_comb_serial
    import ds_decim_pkg::*;
#(
    parameter int ORDER = 3,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] snapshot,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
);

    localparam int SW = (ORDER > 1) ? $clog2(ORDER) : 1;

    comb_state_t   state;
    comb_state_t   state_nxt;
    logic [SW-1:0] stage;
    logic [SW-1:0] stage_nxt;
    logic [W-1:0]  x;
    logic [W-1:0]  dly [ORDER];
    logic          last_stage;

    assign last_stage = (stage == SW'(ORDER - 1));
    assign busy       = (state != ST_IDLE);
    assign result     = x;

    always_comb begin
        state_nxt = state;
        stage_nxt = stage;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_COMB;
                    stage_nxt = '0;
                end
            end
            ST_COMB: begin
                if (last_stage) begin
                    state_nxt = ST_IDLE;
                    stage_nxt = '0;
                end else begin
                    stage_nxt = stage + SW'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                stage_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            stage <= '0;
            x     <= '0;
            done  <= 1'b0;
            for (int k = 0; k < ORDER; k++) begin
                dly[k] <= '0;
            end
        end else begin
            state <= state_nxt;
            stage <= stage_nxt;
            done  <= (state == ST_COMB) && last_stage;
            if (start) begin
                x <= snapshot;
            end else if (state == ST_COMB) begin
                // Differentiator y[n] = x[n] - x[n-1]; modulo-2^W wrap is intended
                // and cancels the integrators' wrap exactly.
                x          <= x - dly[stage];
                dly[stage] <= x;
            end
        end
    end

endmodule

// File: rtl/ds_bitstream_decimator.sv
// Purpose: recover PCM samples from a 1-bit delta-sigma stream with an ORDER-stage CIC (R = 2^DECIM_LOG2).
// Latency: out_valid rises ORDER+1 clocks after the decimating accepted bit.
// Backpressure: single-entry output buffer; a new sample overwrites an unconsumed one and sets sticky overrun.
//
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   in_valid, in_bit     - accepted modulator bit when in_valid is high
//   out_valid, out_ready - output handshake
//   out_sample           - unsigned decimated sample, 0..R^ORDER
//   overrun              - sticky, cleared only by reset
//   busy                 - serial comb in progress

module ds_bitstream_decimator
    import ds_decim_pkg::*;
#(
    parameter  int ORDER      = 3,
    parameter  int DECIM_LOG2 = 5,
    localparam int W          = decim_width(ORDER, DECIM_LOG2)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic         in_bit,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sample,
    output logic         overrun,
    output logic         busy
);

    logic [W-1:0]          acc [ORDER];
    logic [DECIM_LOG2-1:0] count;
    logic                  dec_point;
    logic                  comb_done;
    logic [W-1:0]          comb_result;

    // R is a power of two, so the counter wraps to 0 by itself after R-1.
    assign dec_point = in_valid && (count == '1);

    // Integrator chain. Each stage adds the previous stage's old value, so the
    // chain is pipelined (one extra clock of delay per stage) with no carry chain
    // longer than W bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            for (int k = 0; k < ORDER; k++) begin
                acc[k] <= '0;
            end
        end else if (in_valid) begin
            count  <= count + DECIM_LOG2'(1);
            acc[0] <= acc[0] + {{(W-1){1'b0}}, in_bit};
            for (int k = 1; k < ORDER; k++) begin
                acc[k] <= acc[k] + acc[k-1];
            end
        end
    end

    // The snapshot is the last integrator's value before this edge's update.
    ds_cic_comb_serial #(
        .ORDER (ORDER),
        .W     (W)
    ) u_comb (
        .clk      (clk),
        .reset    (reset),
        .start    (dec_point),
        .snapshot (acc[ORDER-1]),
        .busy     (busy),
        .done     (comb_done),
        .result   (comb_result)
    );

    // Output buffer: a load always wins over a same-cycle handshake. Overrun is
    // only flagged when the old sample was still pending and not being taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_sample <= '0;
            overrun    <= 1'b0;
        end else if (comb_done) begin
            out_valid  <= 1'b1;
            out_sample <= comb_result;
            if (out_valid && !out_ready) begin
                overrun <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // R > ORDER+1 keeps decimation points apart by more than the comb run.
    always_ff @(posedge clk) begin
        if (!reset && dec_point) begin
            assert (!busy);
        end
    end

endmodule
